// File: rtl/fp_classify_pipe_if.sv
// Operand/result handshake bundle for the FCLASS pipeline.
// The slave side is the classifier; the master side is the issuing FPU stage and its writeback consumer.
interface fp_classify_pipe_if #(
  parameter int FLEN  = 64,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             i_valid;
  logic             o_ready;
  logic             i_fmt;
  logic [FLEN-1:0]  i_operand;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_result;
  logic [TAG_W-1:0] o_tag;
  logic             o_busy;

  modport slave (
    input  i_valid, i_fmt, i_operand, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_tag, o_busy
  );

  modport master (
    output i_valid, i_fmt, i_operand, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_tag, o_busy
  );
endinterface

// File: rtl/fp_classify_pipe.sv
// RISC-V FCLASS.S / FCLASS.D unit: classifies an FP operand into the 10-bit class mask and
// carries it with a tag through a STAGES-deep valid/ready pipeline that tolerates writeback stalls.
module fp_classify_pipe #(
  parameter int FLEN   = 64,
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic                i_clk,
  input logic                i_rst_n,
  fp_classify_pipe_if.slave  bus
);

  localparam int LAST = STAGES - 1;

  if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
    $error("fp_classify_pipe: FLEN must be 32 or 64");
  end
  if (XLEN < 10) begin : g_bad_xlen
    $error("fp_classify_pipe: XLEN must be at least 10");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("fp_classify_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("fp_classify_pipe: TAG_W must be at least 1");
  end

  logic useD;
  logic boxOk;
  logic dSign;
  logic dExpOnes;
  logic dExpZero;
  logic dManZero;
  logic dManMsb;

  // Double fields only exist in the 64-bit build; the 32-bit build always classifies as single.
  if (FLEN == 64) begin : g_dbl
    assign useD     = bus.i_fmt;
    assign boxOk    = &bus.i_operand[63:32];
    assign dSign    = bus.i_operand[63];
    assign dExpOnes = &bus.i_operand[62:52];
    assign dExpZero = ~|bus.i_operand[62:52];
    assign dManZero = ~|bus.i_operand[51:0];
    assign dManMsb  = bus.i_operand[51];
  end else begin : g_sgl
    assign useD     = 1'b0;
    assign boxOk    = 1'b1;
    assign dSign    = 1'b0;
    assign dExpOnes = 1'b0;
    assign dExpZero = 1'b0;
    assign dManZero = 1'b0;
    assign dManMsb  = 1'b0;
  end

  logic       sign;
  logic       expOnes;
  logic       expZero;
  logic       manZero;
  logic       manMsb;
  logic [9:0] inMask;

  always_comb begin
    sign    = useD ? dSign    : bus.i_operand[31];
    expOnes = useD ? dExpOnes : &bus.i_operand[30:23];
    expZero = useD ? dExpZero : ~|bus.i_operand[30:23];
    manZero = useD ? dManZero : ~|bus.i_operand[22:0];
    manMsb  = useD ? dManMsb  : bus.i_operand[22];
    inMask  = '0;
    // An improperly NaN-boxed single is read as the canonical quiet NaN.
    if (!useD && !boxOk) begin
      inMask[9] = 1'b1;
    end else if (expOnes) begin
      if (manZero)     inMask[sign ? 0 : 7] = 1'b1;
      else if (manMsb) inMask[9] = 1'b1;
      else             inMask[8] = 1'b1;
    end else if (expZero) begin
      if (manZero) inMask[sign ? 3 : 4] = 1'b1;
      else         inMask[sign ? 2 : 5] = 1'b1;
    end else begin
      inMask[sign ? 1 : 6] = 1'b1;
    end
  end

  logic [STAGES-1:0]            vQ;
  logic [STAGES-1:0]            vD;
  logic [STAGES-1:0][9:0]       maskQ;
  logic [STAGES-1:0][9:0]       maskD;
  logic [STAGES-1:0][TAG_W-1:0] tagQ;
  logic [STAGES-1:0][TAG_W-1:0] tagD;

  logic [STAGES:0]              canTake;
  logic [STAGES:0]              fire;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0][9:0]       srcMask;
  logic [STAGES-1:0][TAG_W-1:0] srcTag;
  logic                         ready;

  // canTake[k]: stage k is free or empties this cycle; canTake[STAGES] is the consumer.
  // fire[k]: the source feeding stage k hands over an op this cycle.
  always_comb begin
    canTake         = '0;
    adv             = '0;
    fire            = '0;
    srcMask         = '0;
    srcTag          = '0;
    canTake[STAGES] = bus.i_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k]     = vQ[k] & canTake[k+1];
      canTake[k] = ~vQ[k] | adv[k];
    end
    ready      = canTake[0] & ~bus.i_flush;
    fire[0]    = bus.i_valid & ready;
    srcMask[0] = inMask;
    srcTag[0]  = bus.i_tag;
    for (int k = 1; k < STAGES; k++) begin
      srcMask[k] = maskQ[k-1];
      srcTag[k]  = tagQ[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      fire[k+1] = adv[k];
    end
  end

  // Flush only kills the valids; payload registers may pick up stale data harmlessly.
  always_comb begin
    vD    = vQ;
    maskD = maskQ;
    tagD  = tagQ;
    for (int k = 0; k < STAGES; k++) begin
      if (canTake[k]) begin
        vD[k] = fire[k];
      end
      if (canTake[k] && fire[k]) begin
        maskD[k] = srcMask[k];
        tagD[k]  = srcTag[k];
      end
    end
    if (bus.i_flush) begin
      vD = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vQ    <= '0;
      maskQ <= '0;
      tagQ  <= '0;
    end else begin
      vQ    <= vD;
      maskQ <= maskD;
      tagQ  <= tagD;
    end
  end

  logic [XLEN-1:0] result;

  always_comb begin
    result      = '0;
    result[9:0] = maskQ[LAST];
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = vQ[LAST];
  assign bus.o_result = result;
  assign bus.o_tag    = tagQ[LAST];
  assign bus.o_busy   = |vQ;

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Self-checking bench for fp_classify_pipe (FLEN=64, STAGES=2): directed vectors, stall, flush and
// async reset, then randomized traffic, all checked by a scoreboard against a field-rule classifier.
module tb_fp_classify_pipe;

  localparam int FLEN   = 64;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  typedef struct {
    logic [9:0]       mask;
    logic [TAG_W-1:0] tag;
    int               acceptCycle;
  } expT;

  logic clk;
  logic rstN;
  int   total;
  int   bad;
  int   cycle;
  int   stallCycle;
  expT  expQ[$];
  bit   holdPrev;
  logic [XLEN-1:0]  prevResult;
  logic [TAG_W-1:0] prevTag;

  fp_classify_pipe_if #(.FLEN(FLEN), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  fp_classify_pipe #(
    .FLEN(FLEN), .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classification straight from the IEEE field rules, using integer field values.
  function automatic logic [9:0] refClass(logic fmt, logic [63:0] op);
    longint unsigned e, m, eMax, quietMin;
    bit neg;
    int idx;
    if (fmt) begin
      neg = op[63];
      e = (op >> 52) & 64'h7FF;
      m = op & ((64'd1 << 52) - 1);
      eMax = 2047;
      quietMin = 64'd1 << 51;
    end else begin
      if ((op >> 32) != 64'hFFFF_FFFF) return 10'h200;
      neg = op[31];
      e = (op >> 23) & 64'hFF;
      m = op & ((64'd1 << 23) - 1);
      eMax = 255;
      quietMin = 64'd1 << 22;
    end
    if (e == eMax) begin
      if (m == 0)             idx = neg ? 0 : 7;
      else if (m >= quietMin) idx = 9;
      else                    idx = 8;
    end else if (e == 0) begin
      if (m == 0) idx = neg ? 3 : 4;
      else        idx = neg ? 2 : 5;
    end else begin
      idx = neg ? 1 : 6;
    end
    return 10'b1 << idx;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: inputs only change just after posedge, so the negedge view is what the edge sees.
  always @(negedge clk) begin
    cycle++;
    if (!rstN) begin
      expQ.delete();
      stallCycle = cycle;
      holdPrev = 0;
    end else if (bus.i_flush) begin
      checkOutput("flush_ready_low", 64'(bus.o_ready), 64'd0);
      expQ.delete();
      stallCycle = cycle;
      holdPrev = 0;
    end else begin
      if (!bus.i_ready) stallCycle = cycle;
      if (holdPrev) begin
        checkOutput("hold_valid", 64'(bus.o_valid), 64'd1);
        checkOutput("hold_result", 64'(bus.o_result), 64'(prevResult));
        checkOutput("hold_tag", 64'(bus.o_tag), 64'(prevTag));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 64'(bus.o_result), 64'hDEAD);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("sb_result", 64'(bus.o_result), 64'(e.mask));
          checkOutput("sb_tag", 64'(bus.o_tag), 64'(e.tag));
          if (e.acceptCycle > stallCycle)
            checkOutput("sb_latency", 64'(cycle - e.acceptCycle), 64'(STAGES));
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        expQ.push_back('{mask: refClass(bus.i_fmt, bus.i_operand), tag: bus.i_tag, acceptCycle: cycle});
      end
      holdPrev = bus.o_valid && !bus.i_ready;
      prevResult = bus.o_result;
      prevTag = bus.o_tag;
    end
  end

  task automatic applyStimulus(input logic fmt, input logic [63:0] op, input logic [TAG_W-1:0] tag);
    bit accepted;
    accepted = 0;
    bus.i_valid = 1'b1;
    bus.i_fmt = fmt;
    bus.i_operand = op;
    bus.i_tag = tag;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.o_ready && !bus.i_flush;
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic runDirected(input logic fmt, input logic [63:0] op, input logic [TAG_W-1:0] tag,
                             input logic [9:0] expected, input string name);
    applyStimulus(fmt, op, tag);
    @(negedge clk);
    @(negedge clk);
    checkOutput({name, "_valid"}, 64'(bus.o_valid), 64'd1);
    checkOutput(name, 64'(bus.o_result), 64'(expected));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.o_busy) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  task automatic randOperand(output logic fmt, output logic [63:0] op);
    logic [63:0] sign, ex, man, eMax, manW;
    fmt = 1'($urandom_range(0, 1));
    eMax = fmt ? 64'd2047 : 64'd255;
    manW = fmt ? 64'd52 : 64'd23;
    sign = 64'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: ex = 0;
      1: ex = eMax;
      default: ex = 64'($urandom) % (eMax + 1);
    endcase
    case ($urandom_range(0, 3))
      0: man = 0;
      1: man = 64'd1 << (manW - 1);
      2: man = 64'd1;
      default: man = {32'($urandom), 32'($urandom)} & ((64'd1 << manW) - 1);
    endcase
    if (fmt) begin
      op = (sign << 63) | (ex << 52) | man;
    end else begin
      op = (sign << 31) | (ex << 23) | man;
      if ($urandom_range(0, 7) == 0) op = op | (64'($urandom) << 32);
      else                           op = op | 64'hFFFF_FFFF_0000_0000;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] stallOps[3];
    logic        f;
    logic [63:0] op;
    int          taken;

    total = 0;
    bad = 0;
    cycle = 0;
    stallCycle = 0;
    holdPrev = 0;
    rstN = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_fmt = 1'b0;
    bus.i_operand = '0;
    bus.i_tag = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;

    #3;
    checkOutput("reset_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("reset_ready", 64'(bus.o_ready), 64'd1);
    checkOutput("reset_result", 64'(bus.o_result), 64'd0);
    checkOutput("reset_tag", 64'(bus.o_tag), 64'd0);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_ready", 64'(bus.o_ready), 64'd1);

    $display("[TB] directed vectors");
    runDirected(1'b0, 64'hFFFF_FFFF_BF80_0000, 5'd1, 10'h002, "s_neg_one");
    runDirected(1'b0, 64'h0000_0000_7FC0_0000, 5'd2, 10'h200, "s_bad_box");
    runDirected(1'b1, 64'h7FF0_0000_0000_0001, 5'd3, 10'h100, "d_snan");
    runDirected(1'b1, 64'h8000_0000_0000_0000, 5'd4, 10'h008, "d_neg_zero");

    $display("[TB] back-to-back");
    applyStimulus(1'b0, 64'hFFFF_FFFF_7F80_0000, 5'd10);
    applyStimulus(1'b0, 64'hFFFF_FFFF_0000_0000, 5'd11);
    applyStimulus(1'b0, 64'hFFFF_FFFF_0000_0001, 5'd12);
    @(negedge clk);
    checkOutput("b2b_second", 64'(bus.o_result), 64'h010);
    checkOutput("b2b_second_tag", 64'(bus.o_tag), 64'd11);
    @(negedge clk);
    checkOutput("b2b_third", 64'(bus.o_result), 64'h020);
    checkOutput("b2b_third_tag", 64'(bus.o_tag), 64'd12);
    @(posedge clk);
    #1;
    waitDrain("b2b_drain");

    $display("[TB] stall");
    stallOps[0] = 64'hFFFF_FFFF_7F80_0000;
    stallOps[1] = 64'h3FF0_0000_0000_0000;
    stallOps[2] = 64'hFFFF_FFFF_8000_0000;
    bus.i_ready = 1'b0;
    taken = 0;
    for (int i = 0; i < 6; i++) begin
      bus.i_valid = 1'b1;
      bus.i_fmt = (taken == 1);
      bus.i_operand = stallOps[taken];
      bus.i_tag = 5'(20 + taken);
      @(negedge clk);
      if (bus.o_ready && taken < 2) taken++;
      else if (bus.o_ready) taken = 3;
      @(posedge clk);
      #1;
    end
    checkOutput("stall_accepted", 64'(taken), 64'd2);
    @(negedge clk);
    checkOutput("stall_ready_low", 64'(bus.o_ready), 64'd0);
    checkOutput("stall_first_mask", 64'(bus.o_result), 64'h080);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    waitDrain("stall_drain");

    $display("[TB] flush");
    bus.i_ready = 1'b0;
    applyStimulus(1'b1, 64'h3FF0_0000_0000_0000, 5'd7);
    applyStimulus(1'b0, 64'hFFFF_FFFF_3F80_0000, 5'd8);
    bus.i_valid = 1'b1;
    bus.i_fmt = 1'b0;
    bus.i_operand = 64'hFFFF_FFFF_FF80_0000;
    bus.i_tag = 5'd9;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("flush_busy", 64'(bus.o_busy), 64'd0);
    @(posedge clk);
    #1;
    runDirected(1'b1, 64'h7FF4_0000_0000_0000, 5'd13, 10'h100, "post_flush_snan");
    waitDrain("flush_drain");

    $display("[TB] async reset");
    applyStimulus(1'b1, 64'h0000_0000_0000_0001, 5'd14);
    applyStimulus(1'b1, 64'hFFF0_0000_0000_0000, 5'd15);
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("arst_result", 64'(bus.o_result), 64'd0);
    checkOutput("arst_busy", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("arst_ready", 64'(bus.o_ready), 64'd1);
    checkOutput("arst_no_output", 64'(bus.o_valid), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      randOperand(f, op);
      bus.i_fmt = f;
      bus.i_operand = op;
      bus.i_tag = 5'($urandom);
      bus.i_valid = ($urandom_range(0, 9) < 7);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_flush = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    waitDrain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
